// File: rtl/hs4_rx_fifo_if.sv
// Receiver-side bundle: 4-phase req/ack/data from the async pipeline and the
// valid/ready word port toward the synchronous consumer.
interface hs4_rx_fifo_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
);
    logic                     hs_req;
    logic [DATA_W-1:0]        hs_data;
    logic                     hs_ack;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_W-1:0]        m_data;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  hs_req, hs_data, m_ready,
        output hs_ack, m_valid, m_data, count
    );

    modport master (
        output hs_req, hs_data, m_ready,
        input  hs_ack, m_valid, m_data, count
    );
endinterface

// File: rtl/hs4_rx_fifo.sv
// Async-to-sync receiver: synchronizes the 4-phase request, captures one word
// per handshake into a first-word-fall-through FIFO and acks upstream.
module hs4_rx_fifo #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    hs4_rx_fifo_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_LOW = 1'b1;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [0:0]             state;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count_q;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic                   push;
    logic                   pop;

    // Only this chain ever samples the raw asynchronous request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.hs_req};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Full test uses the registered count, so a same-cycle pop cannot make room.
    assign push = (state == IDLE) && req_s && (count_q != FULL);
    assign pop  = (count_q != '0) && bus.m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (push)   state <= WAIT_LOW;
                WAIT_LOW: if (!req_s) state <= IDLE;
                default:              state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= bus.hs_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The ack is the WAIT_LOW state flop itself, so it is glitch-free upstream.
    assign bus.hs_ack  = state[0];
    assign bus.m_valid = (count_q != '0);
    assign bus.m_data  = mem[rd_ptr];
    assign bus.count   = count_q;
endmodule

// File: tb/tb_hs4_rx_fifo.sv
// Directed plus randomized bench for hs4_rx_fifo; occupancy and word order are
// tracked by a queue model and compared every clock.
module tb_hs4_rx_fifo;
    localparam int DATA_W      = 16;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hs4_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();

    hs4_rx_fifo #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] q[$];
    logic prev_ack = 1'b0;
    bit   rnd_ready = 1'b0;
    int   max_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model pops before the edge, captures on an observed ack rise.
    task automatic tick();
        int pre_size;
        if (rnd_ready) bus.m_ready = 1'($urandom_range(0, 1));
        pre_size = q.size();
        if (bus.m_ready && q.size() != 0) void'(q.pop_front());
        @(posedge clk);
        #1;
        if (bus.hs_ack === 1'b1 && prev_ack === 1'b0) begin
            chk("capture_not_full", pre_size < DEPTH, 1);
            q.push_back(bus.hs_data);
        end
        prev_ack = bus.hs_ack;
        if (q.size() > max_count) max_count = q.size();
        chk("count", bus.count, q.size());
        chk("m_valid", bus.m_valid, q.size() != 0);
        if (q.size() != 0) chk("m_data", bus.m_data, q[0]);
    endtask

    task automatic wait_ack(input logic level, input int exp_edges, input int limit, input string tag);
        int n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (bus.hs_ack === level) begin
                n = i;
                break;
            end
        end
        if (exp_edges > 0) chk(tag, n, exp_edges);
        else               chk({tag, "_timeout"}, n > 0, 1);
    endtask

    task automatic xfer(input logic [DATA_W-1:0] d, input int exp_edges, input string tag);
        bus.hs_data = d;
        bus.hs_req  = 1'b1;
        wait_ack(1'b1, exp_edges, 60, {tag, "_ack_rise"});
        bus.hs_req  = 1'b0;
        wait_ack(1'b0, SYNC_STAGES + 1, 20, {tag, "_ack_fall"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hs_req  = 1'b0;
        bus.hs_data = '0;
        bus.m_ready = 1'b0;
        rst_n       = 1'b0;
        #20;
        chk("rst_hs_ack", bus.hs_ack, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_m_data", bus.m_data, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        prev_ack = 1'b0;
        tick();

        // Single transfer with consumer stalled
        bus.hs_data = 16'hA1A1;
        bus.hs_req  = 1'b1;
        wait_ack(1'b1, SYNC_STAGES + 1, 10, "single_rise");
        chk("single_m_valid", bus.m_valid, 1);
        chk("single_m_data", bus.m_data, 16'hA1A1);
        chk("single_count", bus.count, 1);
        bus.hs_req = 1'b0;
        wait_ack(1'b0, SYNC_STAGES + 1, 10, "single_fall");
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("single_drained", bus.count, 0);

        // Back-to-back with consumer always ready
        max_count   = 0;
        bus.m_ready = 1'b1;
        xfer(16'hA1A1, SYNC_STAGES + 1, "b2b_a");
        xfer(16'hB2B2, SYNC_STAGES + 1, "b2b_b");
        xfer(16'hC3C3, SYNC_STAGES + 1, "b2b_c");
        tick();
        tick();
        bus.m_ready = 1'b0;
        chk("b2b_max_count", max_count <= 1, 1);
        chk("b2b_empty", bus.count, 0);

        // Fill, stall the fifth request, release with a single pop
        for (int i = 1; i <= DEPTH; i++) xfer(DATA_W'(i), SYNC_STAGES + 1, "fill");
        chk("full_count", bus.count, DEPTH);
        bus.hs_data = 16'h0005;
        bus.hs_req  = 1'b1;
        repeat (8) tick();
        chk("stall_ack", bus.hs_ack, 0);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("stall_pop_ack", bus.hs_ack, 0);
        chk("stall_pop_count", bus.count, DEPTH - 1);
        tick();
        chk("stall_release_ack", bus.hs_ack, 1);
        chk("stall_release_count", bus.count, DEPTH);
        bus.hs_req = 1'b0;
        wait_ack(1'b0, SYNC_STAGES + 1, 10, "stall_fall");
        for (int i = 2; i <= 5; i++) begin
            chk("stall_order", bus.m_data, i);
            bus.m_ready = 1'b1;
            tick();
            bus.m_ready = 1'b0;
        end
        chk("stall_drained", bus.count, 0);

        // Push and pop on the same edge
        xfer(16'h1111, SYNC_STAGES + 1, "sim_a");
        xfer(16'h2222, SYNC_STAGES + 1, "sim_b");
        chk("sim_pre_count", bus.count, 2);
        bus.hs_data = 16'h3333;
        bus.hs_req  = 1'b1;
        tick();
        tick();
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("sim_ack", bus.hs_ack, 1);
        chk("sim_count", bus.count, 2);
        chk("sim_head", bus.m_data, 16'h2222);
        bus.hs_req = 1'b0;
        wait_ack(1'b0, SYNC_STAGES + 1, 10, "sim_fall");
        bus.m_ready = 1'b1;
        repeat (3) tick();
        bus.m_ready = 1'b0;
        chk("sim_drained", bus.count, 0);

        // Random consumer readiness across pointer wrap
        rnd_ready = 1'b1;
        for (int i = 0; i < 10; i++) xfer(DATA_W'($urandom), -1, "wrap");
        rnd_ready   = 1'b0;
        bus.m_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        bus.m_ready = 1'b0;
        chk("wrap_empty", bus.m_valid, 0);

        // Reset while waiting for request low with three words buffered
        xfer(16'hAAAA, SYNC_STAGES + 1, "rst_a");
        xfer(16'hBBBB, SYNC_STAGES + 1, "rst_b");
        bus.hs_data = 16'hCCCC;
        bus.hs_req  = 1'b1;
        wait_ack(1'b1, SYNC_STAGES + 1, 10, "rst_rise");
        chk("rst_pre_count", bus.count, 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_hs_ack", bus.hs_ack, 0);
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_count", bus.count, 0);
        q.delete();
        prev_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ack(1'b1, SYNC_STAGES + 1, 10, "rst_recapture");
        chk("rst_recapture_data", bus.m_data, 16'hCCCC);
        chk("rst_recapture_count", bus.count, 1);
        bus.hs_req = 1'b0;
        wait_ack(1'b0, SYNC_STAGES + 1, 10, "rst_fall");
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("final_empty", bus.count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
